// File: rtl/blueberry_pkg.sv
// Shared definitions for the instruction sequencer: default geometry and
// the control state encoding.
package blueberry_pkg;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        READY  = 2'd1,
        DRIVE  = 2'd2,
        HALTED = 2'd3
    } seq_state_t;

endpackage

// File: rtl/seq_mem.sv
// Program buffer: DEPTH x WIDTH register array, one synchronous write port
// and one asynchronous read port. Contents are not reset.
module seq_mem
    import blueberry_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wAddr,
    input  logic [WIDTH-1:0]         wData,
    input  logic [$clog2(DEPTH)-1:0] rAddr,
    output logic [WIDTH-1:0]         rData
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store one word per write strobe.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wAddr] <= wData;
        end
    end

    assign rData = mem[rAddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: words are loaded into a program buffer in program
// mode, then presented one per external request in run mode. DOE marks the
// single cycle a word is valid toward the bus; the bus tristate lives above.
// Build option: define INSTR_SEQ_LOOP_EN to make the program repeat instead
// of halting after its last word.
module instr_sequencer
    import blueberry_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     CLKb,
    input  logic                     CLR,
    input  logic                     MODE,
    input  logic                     WR,
    input  logic [WIDTH-1:0]         DIN,
    input  logic                     EXT,
    output logic [WIDTH-1:0]         DOUT,
    output logic                     DOE,
    output logic [$clog2(DEPTH)-1:0] PC,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     FULL,
    output logic                     HALT
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    seq_state_t      state, stateNext;
    logic [WIDTH-1:0] doutNext;
    logic            doeNext;
    logic [AW-1:0]   pcNext;
    logic [AW:0]     countNext;
    logic            lastFetch, lastFetchNext;
    logic            memWe;
    logic [WIDTH-1:0] memRdata;
    logic            isLast;
    logic            doFetch;
    logic [AW-1:0]   fetchPc;
    logic            fetchLast;

    seq_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) uMem (
        .clk   (CLKb),
        .we    (memWe),
        .wAddr (COUNT[AW-1:0]),
        .wData (DIN),
        .rAddr (PC),
        .rData (memRdata)
    );

    assign FULL   = (COUNT == FULL_CNT);
    assign HALT   = (state == HALTED);
    assign isLast = ({1'b0, PC} == (COUNT - (AW+1)'(1)));

    // State register plus the registered datapath/control outputs.
    always_ff @(posedge CLKb or posedge CLR) begin
        if (CLR) begin
            state     <= LOAD;
            DOUT      <= '0;
            DOE       <= 1'b0;
            PC        <= '0;
            COUNT     <= '0;
            lastFetch <= 1'b0;
        end else begin
            state     <= stateNext;
            DOUT      <= doutNext;
            DOE       <= doeNext;
            PC        <= pcNext;
            COUNT     <= countNext;
            lastFetch <= lastFetchNext;
        end
    end

    // Next-state and next-output decode; DOE defaults low so it only ever
    // stays high across back-to-back fetches.
    always_comb begin
        stateNext     = state;
        doutNext      = DOUT;
        doeNext       = 1'b0;
        pcNext        = PC;
        countNext     = COUNT;
        lastFetchNext = lastFetch;
        memWe         = 1'b0;
        doFetch       = 1'b0;

`ifdef INSTR_SEQ_LOOP_EN
        fetchPc   = isLast ? '0 : PC + AW'(1);
        fetchLast = 1'b0;
`else
        fetchPc   = PC + AW'(1);
        fetchLast = isLast;
`endif

        if (state == LOAD) begin
            if (MODE) begin
                pcNext        = '0;
                lastFetchNext = 1'b0;
                stateNext     = (COUNT == '0) ? HALTED : READY;
            end else if (WR && !FULL) begin
                memWe     = 1'b1;
                countNext = COUNT + (AW+1)'(1);
            end
        end else if (!MODE) begin
            // Leaving run mode: back to program mode with an empty count.
            stateNext     = LOAD;
            doutNext      = '0;
            pcNext        = '0;
            countNext     = '0;
            lastFetchNext = 1'b0;
        end else begin
            case (state)
                READY: begin
                    doFetch = EXT;
                end
                DRIVE: begin
                    if (lastFetch) begin
                        stateNext     = HALTED;
                        lastFetchNext = 1'b0;
                    end else if (EXT) begin
                        doFetch = 1'b1;
                    end else begin
                        stateNext = READY;
                    end
                end
                default: begin
                end
            endcase

            if (doFetch) begin
                doutNext      = memRdata;
                doeNext       = 1'b1;
                pcNext        = fetchPc;
                lastFetchNext = fetchLast;
                stateNext     = DRIVE;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    localparam int W = 10;
    localparam int D = 16;

    logic          CLKb = 1'b0;
    logic          CLR  = 1'b1;
    logic          MODE = 1'b0;
    logic          WR   = 1'b0;
    logic [W-1:0]  DIN  = '0;
    logic          EXT  = 1'b0;
    logic [W-1:0]  DOUT;
    logic          DOE;
    logic [3:0]    PC;
    logic [4:0]    COUNT;
    logic          FULL;
    logic          HALT;

    int checks = 0;
    int errors = 0;

    instr_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .CLKb  (CLKb),
        .CLR   (CLR),
        .MODE  (MODE),
        .WR    (WR),
        .DIN   (DIN),
        .EXT   (EXT),
        .DOUT  (DOUT),
        .DOE   (DOE),
        .PC    (PC),
        .COUNT (COUNT),
        .FULL  (FULL),
        .HALT  (HALT)
    );

    always #5 CLKb = ~CLKb;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

`ifdef INSTR_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [W-1:0] eDout, input logic eDoe,
                            input logic [3:0] ePc, input logic [4:0] eCount,
                            input logic eFull, input logic eHalt);
        check({tag, ".DOUT"},  32'(DOUT),  32'(eDout));
        check({tag, ".DOE"},   32'(DOE),   32'(eDoe));
        check({tag, ".PC"},    32'(PC),    32'(ePc));
        check({tag, ".COUNT"}, 32'(COUNT), 32'(eCount));
        check({tag, ".FULL"},  32'(FULL),  32'(eFull));
        check({tag, ".HALT"},  32'(HALT),  32'(eHalt));
    endtask

    task automatic tick();
        @(posedge CLKb);
        #1;
    endtask

    task automatic doReset();
        CLR = 1'b1; MODE = 1'b0; WR = 1'b0; EXT = 1'b0; DIN = '0;
        tick();
        CLR = 1'b0;
    endtask

    task automatic step(input logic m, input logic w, input logic [W-1:0] d, input logic e);
        MODE = m; WR = w; DIN = d; EXT = e;
        tick();
    endtask

    // ---------------- reference model ----------------
    // Program held as an array of words; progress tracked as an integer
    // index into the loaded program.
    int          mCount;
    logic [W-1:0] mProg [D];
    bit          mRun, mHalted, mDriving;
    int          mIdx;
    logic [W-1:0] mOut;

    function automatic void modelReset();
        mCount = 0; mRun = 0; mHalted = 0; mDriving = 0; mIdx = 0; mOut = '0;
    endfunction

    function automatic void modelStep(input bit clr, input bit m, input bit w,
                                      input logic [W-1:0] d, input bit e);
        if (clr) begin
            modelReset();
        end else if (!mRun) begin
            if (m) begin
                mRun = 1; mIdx = 0; mDriving = 0; mHalted = (mCount == 0);
            end else if (w && mCount < D) begin
                mProg[mCount] = d;
                mCount++;
            end
        end else if (!m) begin
            mRun = 0; mDriving = 0; mHalted = 0; mCount = 0; mIdx = 0; mOut = '0;
        end else if (!mHalted) begin
            if (!LOOP && mDriving && mIdx == mCount) begin
                mHalted = 1; mDriving = 0;
            end else if (e) begin
                mOut = mProg[mIdx];
                mIdx++;
                if (LOOP && mIdx == mCount) mIdx = 0;
                mDriving = 1;
            end else begin
                mDriving = 0;
            end
        end
    endfunction

    typedef struct {
        logic         mode, wr, ext;
        logic [W-1:0] din;
        logic [W-1:0] eDout;
        logic         eDoe;
        logic [3:0]   ePc;
        logic [4:0]   eCount;
        logic         eFull, eHalt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic m, logic w, logic e, logic [W-1:0] d,
                                logic [W-1:0] o, logic oe, logic [3:0] p,
                                logic [4:0] c, logic f, logic h);
        vec_t v;
        v.mode = m; v.wr = w; v.ext = e; v.din = d;
        v.eDout = o; v.eDoe = oe; v.ePc = p; v.eCount = c; v.eFull = f; v.eHalt = h;
        return v;
    endfunction

    initial begin
        // Reset state, asserted from time zero.
        #1;
        checkAll("reset", '0, 0, 0, 0, 0, 0);
        tick();
        CLR = 1'b0;

        // Load three words (EXT in LOAD ignored), run, fetch, halt/loop,
        // return to LOAD, then run with an empty program.
        vecs.push_back(mk(0, 1, 1, 10'h201, 10'h000, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 10'h0F3, 10'h000, 0, 0, 2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 10'h3FF, 10'h000, 0, 0, 3, 0, 0));
        vecs.push_back(mk(1, 0, 0, 10'h155, 10'h000, 0, 0, 3, 0, 0));
        vecs.push_back(mk(1, 1, 0, 10'h155, 10'h000, 0, 0, 3, 0, 0));
        vecs.push_back(mk(1, 0, 1, 10'h000, 10'h201, 1, 1, 3, 0, 0));
        vecs.push_back(mk(1, 0, 1, 10'h000, 10'h0F3, 1, 2, 3, 0, 0));
        if (LOOP) begin
            vecs.push_back(mk(1, 0, 1, 10'h000, 10'h3FF, 1, 0, 3, 0, 0));
            vecs.push_back(mk(1, 0, 1, 10'h000, 10'h201, 1, 1, 3, 0, 0));
            vecs.push_back(mk(1, 0, 1, 10'h000, 10'h0F3, 1, 2, 3, 0, 0));
        end else begin
            vecs.push_back(mk(1, 0, 1, 10'h000, 10'h3FF, 1, 3, 3, 0, 0));
            vecs.push_back(mk(1, 0, 1, 10'h000, 10'h3FF, 0, 3, 3, 0, 1));
            vecs.push_back(mk(1, 0, 1, 10'h000, 10'h3FF, 0, 3, 3, 0, 1));
        end
        vecs.push_back(mk(0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 10'h000, 10'h000, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].mode, vecs[i].wr, vecs[i].din, vecs[i].ext);
            checkAll($sformatf("vec%0d", i), vecs[i].eDout, vecs[i].eDoe, vecs[i].ePc,
                     vecs[i].eCount, vecs[i].eFull, vecs[i].eHalt);
        end

        // Fill beyond capacity: 17th strobe discarded, then read all back.
        doReset();
        for (int i = 1; i <= 17; i++) step(0, 1, W'(i), 0);
        check("fill.COUNT", 32'(COUNT), 16);
        check("fill.FULL",  32'(FULL),  1);
        step(1, 0, '0, 0);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, '0, 1);
            check($sformatf("fill.DOUT%0d", i), 32'(DOUT), 32'(i + 1));
            check($sformatf("fill.DOE%0d", i),  32'(DOE),  1);
        end
        step(1, 0, '0, 0);
        check("fill.endDOE",  32'(DOE),  0);
        check("fill.endHALT", 32'(HALT), LOOP ? 0 : 1);
        check("fill.endDOUT", 32'(DOUT), 16);

        // Asynchronous clear in the middle of a drive cycle.
        doReset();
        step(0, 1, 10'h2AA, 0);
        step(1, 0, '0, 0);
        step(1, 0, '0, 1);
        check("clr.preDOE", 32'(DOE), 1);
        EXT = 1'b0;
        #2 CLR = 1'b1;
        #1;
        checkAll("clrMid", '0, 0, 0, 0, 0, 0);
        #1 CLR = 1'b0;

        // Mode drop while driving.
        doReset();
        step(0, 1, 10'h0AB, 0);
        step(0, 1, 10'h0CD, 0);
        step(1, 0, '0, 0);
        step(1, 0, '0, 1);
        check("mdrop.preDOE", 32'(DOE), 1);
        step(0, 0, '0, 1);
        checkAll("mdrop", '0, 0, 0, 0, 0, 0);
        step(0, 1, 10'h111, 0);
        check("mdrop.loadCOUNT", 32'(COUNT), 1);

`ifdef INSTR_SEQ_LOOP_EN
        // Two-word program repeated by five separate EXT pulses.
        begin
            logic [W-1:0] expSeq [5];
            expSeq[0] = 10'h011; expSeq[1] = 10'h022; expSeq[2] = 10'h011;
            expSeq[3] = 10'h022; expSeq[4] = 10'h011;
            doReset();
            step(0, 1, 10'h011, 0);
            step(0, 1, 10'h022, 0);
            step(1, 0, '0, 0);
            for (int i = 0; i < 5; i++) begin
                step(1, 0, '0, 1);
                check($sformatf("loop.DOUT%0d", i), 32'(DOUT), 32'(expSeq[i]));
                check($sformatf("loop.DOE%0d", i),  32'(DOE),  1);
                check($sformatf("loop.HALT%0d", i), 32'(HALT), 0);
                step(1, 0, '0, 0);
            end
        end
`endif

        // Randomized run against the reference model.
        doReset();
        modelReset();
        begin
            bit m = 0;
            for (int n = 0; n < 3000; n++) begin
                bit c, w, e;
                logic [W-1:0] d;
                if ($urandom_range(0, 19) == 0) m = !m;
                c = ($urandom_range(0, 249) == 0);
                w = $urandom_range(0, 1);
                e = ($urandom_range(0, 3) != 0);
                d = W'($urandom);
                CLR = c; MODE = m; WR = w; DIN = d; EXT = e;
                tick();
                modelStep(c, m, w, d, e);
                checkAll($sformatf("rnd%0d", n), mOut, mDriving, 4'(mIdx % D),
                         5'(mCount), mCount == D, mRun && mHalted);
            end
            CLR = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 10, bus/instruction word width.
REQ-002 SHALL have parameter DEPTH, default 16, program buffer entries (power of two).
REQ-003 SHALL have port CLKb  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port CLR  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port MODE  input  1  0 = program (load), 1 = run.
REQ-006 SHALL have port WR  input  1  one-cycle write strobe, program mode only.
REQ-007 SHALL have port DIN  input  WIDTH  word to store (switch value).
REQ-008 SHALL have port EXT  input  1  controller request for next external word.
REQ-009 SHALL have port DOUT  output  WIDTH  word presented toward bus.
REQ-010 SHALL have port DOE  output  1  bus drive enable; top tristates bus when low.
REQ-011 SHALL have port PC  output  log2(DEPTH)  next read index.
REQ-012 SHALL have port COUNT  output  log2(DEPTH)+1  stored word count.
REQ-013 SHALL have port FULL  output  1  COUNT == DEPTH.
REQ-014 SHALL have port HALT  output  1  program exhausted.

Function
REQ-015 SHALL implement states LOAD, READY, DRIVE, HALTED.
REQ-016 LOAD: WR=1 and not FULL -> mem[COUNT] <= DIN, COUNT+1; WR when FULL ignored, COUNT unchanged.
REQ-017 LOAD -> READY on MODE=1; PC <= 0 on that edge; COUNT=0 at transition -> HALTED instead.
REQ-018 READY with EXT=1 -> DOUT <= mem[PC], DOE <= 1, PC+1, next state DRIVE; one-cycle latency EXT to DOE.
REQ-019 DRIVE: DOE held exactly one cycle; EXT still high -> back-to-back fetch (stay DRIVE); else -> READY with DOE=0.
REQ-020 Fetch that consumes index COUNT-1 -> after its DRIVE cycle go HALTED; further EXT ignored.
REQ-021 HALTED: DOE=0, HALT=1, DOUT holds last word.
REQ-022 MODE=0 in any run state -> LOAD next edge, DOE=0 same edge, COUNT<=0, PC<=0, HALT<=0; buffer contents not cleared.
REQ-023 WR in any run state SHALL be ignored; EXT in LOAD SHALL be ignored.
REQ-024 DOUT SHALL change only on a fetch edge, reset, or to 0 on entry to LOAD.
REQ-025 PC arithmetic modulo DEPTH; COUNT saturates at DEPTH.

Reset
REQ-026 CLR=1 SHALL immediately force state LOAD, DOUT=0, DOE=0, PC=0, COUNT=0, FULL=0, HALT=0.
REQ-027 CLR asserted mid-DRIVE SHALL drop DOE asynchronously, no partial word.
REQ-028 Buffer storage need not be reset.

Configuration
REQ-029 Macro INSTR_SEQ_LOOP_EN defined: fetch of index COUNT-1 wraps PC to 0, stays READY/DRIVE, HALTED never entered from run (COUNT=0 still -> HALTED).
REQ-030 Macro undefined: halt behaviour of REQ-020 applies.

Structure
REQ-031 Shared package blueberry_pkg SHALL hold WIDTH/DEPTH defaults and seq_state_t enum.
REQ-032 Storage SHALL be sub-module seq_mem (DEPTH x WIDTH register array, one write port, one async read port).
REQ-033 Control FSM, PC, COUNT in instr_sequencer; no tristate inside the block.

Verification
REQ-034 CLR pulse during DRIVE -> DOE=0 before next edge, all outputs reset values.
REQ-035 Load 3'h? words 10'h201,10'h0F3,10'h3FF, MODE=1, EXT high 3 cycles -> DOUT 201,0F3,3FF on consecutive cycles, DOE=1 each, then HALT=1, DOE=0.
REQ-036 17 WR strobes with DIN=1..17 -> COUNT=16, FULL=1, mem[15]=16, 17th discarded.
REQ-037 MODE=1 with COUNT=0 -> HALTED next edge, EXT pulse -> DOE stays 0.
REQ-038 INSTR_SEQ_LOOP_EN, 2 words 10'h011,10'h022, 5 EXT pulses -> DOUT 011,022,011,022,011, HALT=0.
REQ-039 MODE dropped to 0 while DOE=1 -> next edge DOE=0, COUNT=0, PC=0, state LOAD.
